// File: rtl/systolic_matrix_multiplier.sv
// Output-stationary MxP systolic array computing C = A x B on signed operands.
// Optional clamping of results (with sat_flag port) is enabled by defining SMM_SATURATE_EN.
module systolic_matrix_multiplier #(
  parameter int DATA_WIDTH = 8,
  parameter int M = 8,
  parameter int N = 8,
  parameter int P = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [M*N*DATA_WIDTH-1:0]    matrix_a,
  input  logic [N*P*DATA_WIDTH-1:0]    matrix_b,
  output logic                         done,
`ifdef SMM_SATURATE_EN
  output logic                         sat_flag,
`endif
  output logic [M*P*DATA_WIDTH-1:0]    result_c
);

  localparam int ACC_WIDTH = 2*DATA_WIDTH + $clog2(N) + 1;
  localparam int LAST      = M + N + P - 2;
  localparam int CNT_W     = $clog2(LAST + 2);
  localparam int KW        = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic accept, last;

  logic signed [DATA_WIDTH-1:0]   a_mat  [M][N];
  logic signed [DATA_WIDTH-1:0]   b_mat  [N][P];
  logic signed [DATA_WIDTH-1:0]   a_in   [M][P];
  logic signed [DATA_WIDTH-1:0]   b_in   [M][P];
  logic signed [DATA_WIDTH-1:0]   a_pipe [M][P-1];
  logic signed [DATA_WIDTH-1:0]   b_pipe [M-1][P];
  logic signed [2*DATA_WIDTH-1:0] prod   [M][P];
  logic signed [ACC_WIDTH-1:0]    acc    [M][P];
  logic [M*P*DATA_WIDTH-1:0]      c_val;
`ifdef SMM_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH-1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
  logic sat_any;
`endif

  assign accept = start && (state != S_COMPUTE);
  assign last   = (cnt == CNT_W'(LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (start) state_nxt = S_COMPUTE;
      S_COMPUTE: if (last)  state_nxt = S_DONE;
      S_DONE:    if (start) state_nxt = S_COMPUTE;
      default:              state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    done = (state == S_DONE);
  end

  // Skewed edge feeds: row i sees A[i][cnt-i], column j sees B[cnt-j][j].
  always_comb begin
    int kk;
    kk = 0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < P; j++) begin
        a_in[i][j] = '0;
        b_in[i][j] = '0;
      end
    for (int i = 0; i < M; i++) begin
      kk = int'(cnt) - i;
      if (kk >= 0 && kk < N) a_in[i][0] = a_mat[i][kk[KW-1:0]];
      for (int j = 1; j < P; j++) a_in[i][j] = a_pipe[i][j-1];
    end
    for (int j = 0; j < P; j++) begin
      kk = int'(cnt) - j;
      if (kk >= 0 && kk < N) b_in[0][j] = b_mat[kk[KW-1:0]][j];
      for (int i = 1; i < M; i++) b_in[i][j] = b_pipe[i-1][j];
    end
  end

  always_comb begin
    for (int i = 0; i < M; i++)
      for (int j = 0; j < P; j++)
        prod[i][j] = a_in[i][j] * b_in[i][j];
  end

  always_comb begin
    c_val = '0;
`ifdef SMM_SATURATE_EN
    sat_any = 1'b0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < P; j++) begin
        if (acc[i][j] > SAT_MAX) begin
          c_val[(i*P+j)*DATA_WIDTH +: DATA_WIDTH] = SAT_MAX[DATA_WIDTH-1:0];
          sat_any = 1'b1;
        end else if (acc[i][j] < SAT_MIN) begin
          c_val[(i*P+j)*DATA_WIDTH +: DATA_WIDTH] = SAT_MIN[DATA_WIDTH-1:0];
          sat_any = 1'b1;
        end else begin
          c_val[(i*P+j)*DATA_WIDTH +: DATA_WIDTH] = acc[i][j][DATA_WIDTH-1:0];
        end
      end
`else
    for (int i = 0; i < M; i++)
      for (int j = 0; j < P; j++)
        c_val[(i*P+j)*DATA_WIDTH +: DATA_WIDTH] = acc[i][j][DATA_WIDTH-1:0];
`endif
  end

  // The final COMPUTE cycle only drains zeros; the result is captured from acc as it stands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      result_c <= '0;
`ifdef SMM_SATURATE_EN
      sat_flag <= 1'b0;
`endif
      for (int i = 0; i < M; i++)
        for (int k = 0; k < N; k++) a_mat[i][k] <= '0;
      for (int k = 0; k < N; k++)
        for (int j = 0; j < P; j++) b_mat[k][j] <= '0;
      for (int i = 0; i < M; i++)
        for (int j = 0; j < P; j++) acc[i][j] <= '0;
      for (int i = 0; i < M; i++)
        for (int j = 0; j < P-1; j++) a_pipe[i][j] <= '0;
      for (int i = 0; i < M-1; i++)
        for (int j = 0; j < P; j++) b_pipe[i][j] <= '0;
    end else if (accept) begin
      cnt <= '0;
`ifdef SMM_SATURATE_EN
      sat_flag <= 1'b0;
`endif
      for (int i = 0; i < M; i++)
        for (int k = 0; k < N; k++)
          a_mat[i][k] <= matrix_a[(i*N+k)*DATA_WIDTH +: DATA_WIDTH];
      for (int k = 0; k < N; k++)
        for (int j = 0; j < P; j++)
          b_mat[k][j] <= matrix_b[(k*P+j)*DATA_WIDTH +: DATA_WIDTH];
      for (int i = 0; i < M; i++)
        for (int j = 0; j < P; j++) acc[i][j] <= '0;
      for (int i = 0; i < M; i++)
        for (int j = 0; j < P-1; j++) a_pipe[i][j] <= '0;
      for (int i = 0; i < M-1; i++)
        for (int j = 0; j < P; j++) b_pipe[i][j] <= '0;
    end else if (state == S_COMPUTE) begin
      cnt <= cnt + 1'b1;
      for (int i = 0; i < M; i++)
        for (int j = 0; j < P; j++)
          acc[i][j] <= acc[i][j] +
            {{(ACC_WIDTH-2*DATA_WIDTH){prod[i][j][2*DATA_WIDTH-1]}}, prod[i][j]};
      for (int i = 0; i < M; i++)
        for (int j = 0; j < P-1; j++) a_pipe[i][j] <= a_in[i][j];
      for (int i = 0; i < M-1; i++)
        for (int j = 0; j < P; j++) b_pipe[i][j] <= b_in[i][j];
      if (last) begin
        result_c <= c_val;
`ifdef SMM_SATURATE_EN
        sat_flag <= sat_any;
`endif
      end
    end
  end

endmodule

// File: tb/tb_systolic_matrix_multiplier.sv
// Scoreboard bench for systolic_matrix_multiplier: driver queues reference results,
// a negedge monitor checks each done rising edge for result and latency.
module tb_systolic_matrix_multiplier;
  localparam int DW  = 8;
  localparam int M   = 8;
  localparam int N   = 8;
  localparam int P   = 8;
  localparam int AW  = M*N*DW;
  localparam int BW  = N*P*DW;
  localparam int CW  = M*P*DW;
  localparam int LAT = M + N + P - 1;

  logic clk = 1'b0;
  logic rst, start, done;
  logic [AW-1:0] matrix_a;
  logic [BW-1:0] matrix_b;
  logic [CW-1:0] result_c;
`ifdef SMM_SATURATE_EN
  logic sat_flag;
`endif

  systolic_matrix_multiplier #(.DATA_WIDTH(DW), .M(M), .N(N), .P(P)) dut (
    .clk(clk), .rst(rst), .start(start),
    .matrix_a(matrix_a), .matrix_b(matrix_b),
    .done(done),
`ifdef SMM_SATURATE_EN
    .sat_flag(sat_flag),
`endif
    .result_c(result_c)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [CW-1:0] exp_q[$];
  int            start_q[$];
  bit            sat_q[$];
  logic [CW-1:0] last_exp = '0;
  logic [CW-1:0] mon_exp;
  int            mon_start;
  bit            mon_sat;
  bit            prev_done = 1'b0;

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer dot products, then wrap (or clamp) to DW bits.
  function automatic logic [CW-1:0] ref_mul(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                            output bit sat);
    logic [CW-1:0] c;
    int s;
    c = '0;
    sat = 1'b0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < P; j++) begin
        s = 0;
        for (int k = 0; k < N; k++)
          s += int'($signed(a[(i*N+k)*DW +: DW])) * int'($signed(b[(k*P+j)*DW +: DW]));
`ifdef SMM_SATURATE_EN
        if (s > (2**(DW-1)) - 1) begin s = (2**(DW-1)) - 1; sat = 1'b1; end
        if (s < -(2**(DW-1)))    begin s = -(2**(DW-1));    sat = 1'b1; end
`endif
        c[(i*P+j)*DW +: DW] = s[DW-1:0];
      end
    return c;
  endfunction

  function automatic logic [AW-1:0] fill_a(input int v);
    logic [AW-1:0] r;
    for (int e = 0; e < M*N; e++) r[e*DW +: DW] = DW'(v);
    return r;
  endfunction

  function automatic logic [BW-1:0] fill_b(input int v);
    logic [BW-1:0] r;
    for (int e = 0; e < N*P; e++) r[e*DW +: DW] = DW'(v);
    return r;
  endfunction

  function automatic logic [AW-1:0] rand_a();
    logic [AW-1:0] r;
    for (int e = 0; e < M*N; e++) r[e*DW +: DW] = DW'($urandom());
    return r;
  endfunction

  function automatic logic [BW-1:0] rand_b();
    logic [BW-1:0] r;
    for (int e = 0; e < N*P; e++) r[e*DW +: DW] = DW'($urandom());
    return r;
  endfunction

  always @(negedge clk) begin
    if (done && !prev_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending operation", cyc);
      end else begin
        mon_exp   = exp_q.pop_front();
        mon_start = start_q.pop_front();
        mon_sat   = sat_q.pop_front();
        last_exp  = mon_exp;
        check_vec("result", result_c, mon_exp);
        check_int("latency", cyc - mon_start, LAT);
`ifdef SMM_SATURATE_EN
        check_int("sat_flag", int'(sat_flag), int'(mon_sat));
`endif
      end
    end
    prev_done = done;
  end

  task automatic push_expected(input logic [AW-1:0] a, input logic [BW-1:0] b);
    bit s;
    exp_q.push_back(ref_mul(a, b, s));
    sat_q.push_back(s);
    start_q.push_back(cyc);
  endtask

  // Inputs are scrambled right after the start edge; the latched operands must be used.
  task automatic issue(input logic [AW-1:0] a, input logic [BW-1:0] b);
    @(negedge clk);
    matrix_a = a;
    matrix_b = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    push_expected(a, b);
    check_int("done_clear", int'(done), 0);
    start    = 1'b0;
    matrix_a = rand_a();
    matrix_b = rand_b();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending results expected 0", exp_q.size());
      exp_q.delete();
      start_q.delete();
      sat_q.delete();
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_done: got done=0 expected done=1 within 100 cycles");
    end
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    rst = 1'b1; start = 1'b0; matrix_a = '0; matrix_b = '0;
    repeat (2) @(negedge clk);
    check_int("reset_done", int'(done), 0);
    check_vec("reset_result", result_c, '0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < M; i++)
      for (int k = 0; k < N; k++) a[(i*N+k)*DW +: DW] = DW'(i == k);
    for (int k = 0; k < N; k++)
      for (int j = 0; j < P; j++) b[(k*P+j)*DW +: DW] = DW'(k*P + j);
    issue(a, b);
    wait_idle();
    repeat (3) @(negedge clk);
    check_int("hold_done", int'(done), 1);
    check_vec("hold_result", result_c, last_exp);

    issue(fill_a(8'h01), fill_b(8'h01)); wait_idle();
    issue(fill_a(8'h7F), fill_b(8'h7F)); wait_idle();
    issue(fill_a(8'hFF), fill_b(8'h02)); wait_idle();

    // Random runs, the first with a start re-pulse mid-COMPUTE that must be ignored.
    for (int r = 0; r < 4; r++) begin
      issue(rand_a(), rand_b());
      if (r == 0) begin
        repeat (4) @(negedge clk);
        matrix_a = rand_a();
        matrix_b = rand_b();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      wait_idle();
    end

    // start held high across DONE: two back-to-back runs, done low after the second accept.
    a = rand_a();
    b = rand_b();
    @(negedge clk);
    matrix_a = a; matrix_b = b; start = 1'b1;
    @(posedge clk); #1;
    push_expected(a, b);
    @(negedge clk);
    wait_done();
    @(posedge clk); #1;
    push_expected(a, b);
    check_int("b2b_done_drop", int'(done), 0);
    start = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of COMPUTE.
    issue(rand_a(), rand_b());
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check_int("abort_done", int'(done), 0);
    check_vec("abort_result", result_c, '0);
    exp_q.delete(); start_q.delete(); sat_q.delete();
    @(negedge clk);
    rst = 1'b0;
    issue(rand_a(), rand_b());
    wait_idle();

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
